// File: rtl/bcd_count_ctrl.sv
// Two-digit counter controller: switch edges drive a bounded count, converted serially to BCD.
// Optional auto-repeat of held Inc/Dec switches is enabled by defining BCD_COUNT_CTRL_AUTO_REPEAT_EN.
module bcd_count_ctrl #(
  parameter int MAX_COUNT   = 99,
  parameter int COUNT_WIDTH = 7,
  parameter int HOLD_CYCLES = 12500000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Switch_Inc,
  input  logic                   i_Switch_Dec,
  input  logic                   i_Switch_Clr,
  output logic [COUNT_WIDTH-1:0] o_Count,
  output logic [3:0]             o_BCD_Ones,
  output logic [3:0]             o_BCD_Tens,
  output logic                   o_BCD_Valid,
  output logic                   o_Busy
);

  localparam int BW = $clog2(COUNT_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_C  = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [BW-1:0]          BITS_C = BW'(COUNT_WIDTH);

  if (MAX_COUNT < 1 || MAX_COUNT > 99 || (2 ** COUNT_WIDTH) <= MAX_COUNT || HOLD_CYCLES < 1) begin : g_bad_params
    $error("bcd_count_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      return nib + 4'd3;
    end else begin
      return nib;
    end
  endfunction

  state_t                 state_r;
  logic                   inc_prev_r, dec_prev_r, clr_prev_r;
  logic                   pending_r;
  logic [COUNT_WIDTH-1:0] shift_r;
  logic [7:0]             scratch_r;
  logic [BW-1:0]          bit_cnt_r;

  logic                   rep_inc_s, rep_dec_s;
  logic                   inc_press_s, dec_press_s, clr_press_s;
  logic                   cmd_s;
  logic [COUNT_WIDTH-1:0] next_count_s;
  logic [7:0]             adj_s;

`ifdef BCD_COUNT_CTRL_AUTO_REPEAT_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold_cnt_r;
  logic          hold_ok_s, rep_s;

  // Hold qualifies only while the same single Inc/Dec switch stays high with no pattern change.
  always_comb begin
    hold_ok_s = (i_Switch_Inc ^ i_Switch_Dec) & ~i_Switch_Clr &
                (i_Switch_Inc == inc_prev_r) & (i_Switch_Dec == dec_prev_r) &
                (i_Switch_Clr == clr_prev_r);
    rep_s     = hold_ok_s && (hold_cnt_r == HW'(HOLD_CYCLES - 1));
    rep_inc_s = rep_s & i_Switch_Inc;
    rep_dec_s = rep_s & i_Switch_Dec;
  end

  // Hold counter restarts after each synthetic press or any release/change.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_cnt_r <= '0;
    end else if (!hold_ok_s || rep_s) begin
      hold_cnt_r <= '0;
    end else begin
      hold_cnt_r <= hold_cnt_r + HW'(1);
    end
  end
`else
  assign rep_inc_s = 1'b0;
  assign rep_dec_s = 1'b0;
`endif

  // Command decode: Clr wins, Inc+Dec together cancel, otherwise wrap within 0..MAX_COUNT.
  always_comb begin
    inc_press_s  = (i_Switch_Inc & ~inc_prev_r) | rep_inc_s;
    dec_press_s  = (i_Switch_Dec & ~dec_prev_r) | rep_dec_s;
    clr_press_s  = i_Switch_Clr & ~clr_prev_r;
    next_count_s = o_Count;
    cmd_s        = 1'b0;
    adj_s        = {dabble_adj(scratch_r[7:4]), dabble_adj(scratch_r[3:0])};
    if (clr_press_s) begin
      next_count_s = '0;
      cmd_s        = 1'b1;
    end else if (inc_press_s && dec_press_s) begin
      next_count_s = o_Count;
      cmd_s        = 1'b0;
    end else if (inc_press_s) begin
      next_count_s = (o_Count == MAX_C) ? '0 : o_Count + COUNT_WIDTH'(1);
      cmd_s        = 1'b1;
    end else if (dec_press_s) begin
      next_count_s = (o_Count == '0) ? MAX_C : o_Count - COUNT_WIDTH'(1);
      cmd_s        = 1'b1;
    end else begin
      next_count_s = o_Count;
      cmd_s        = 1'b0;
    end
  end

  // Count, edge history and the serial double-dabble sequencer.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r     <= IDLE;
      inc_prev_r  <= 1'b0;
      dec_prev_r  <= 1'b0;
      clr_prev_r  <= 1'b0;
      pending_r   <= 1'b0;
      shift_r     <= '0;
      scratch_r   <= 8'd0;
      bit_cnt_r   <= '0;
      o_Count     <= '0;
      o_BCD_Ones  <= 4'd0;
      o_BCD_Tens  <= 4'd0;
      o_BCD_Valid <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      inc_prev_r  <= i_Switch_Inc;
      dec_prev_r  <= i_Switch_Dec;
      clr_prev_r  <= i_Switch_Clr;
      o_Count     <= next_count_s;
      o_BCD_Valid <= 1'b0;
      // A command arriving on the load edge re-arms pending so the newer count is converted too.
      if (state_r == IDLE && pending_r) begin
        pending_r <= cmd_s;
      end else begin
        pending_r <= pending_r | cmd_s;
      end
      case (state_r)
        IDLE: begin
          if (pending_r) begin
            shift_r   <= o_Count;
            scratch_r <= 8'd0;
            bit_cnt_r <= BITS_C;
            o_Busy    <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            state_r   <= IDLE;
          end
        end
        SHIFT: begin
          scratch_r <= {adj_s[6:0], shift_r[COUNT_WIDTH-1]};
          shift_r   <= shift_r << 1;
          bit_cnt_r <= bit_cnt_r - BW'(1);
          if (bit_cnt_r == BW'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          o_BCD_Tens  <= scratch_r[7:4];
          o_BCD_Ones  <= scratch_r[3:0];
          o_BCD_Valid <= 1'b1;
          o_Busy      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
